// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NREQ producers (wclk domain).
// Optional burst lock-in via `FIFO_ARB_BURST_EN (up to MAX_BURST back-to-back writes per grant).
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 6,
    parameter int MAX_BURST = 4,
    parameter int CNTW      = 16,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic                  wfull,
    output logic [NREQ-1:0]       ack,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDW-1:0]        gnt_id,
    output logic [CNTW-1:0]       wr_cnt
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [CNTW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [IDW-1:0]   sel, sel_nxt;
    logic             found, fire;
    logic [DSIZE-1:0] data_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_a[g] = req_data[g*DSIZE +: DSIZE];
    end

    // Rotating priority scan starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        int s;
        sel   = '0;
        found = 1'b0;
        s     = 0;
        for (int k = 0; k < NREQ; k++) begin
            s = int'(ptr_q) + k;
            if (s >= NREQ) s = s - NREQ;
            if (!found && req[s[IDW-1:0]]) begin
                found = 1'b1;
                sel   = s[IDW-1:0];
            end
        end
    end

    assign sel_nxt = (sel == IDW'(NREQ-1)) ? '0 : sel + IDW'(1);
    assign fire    = found & ~wfull & ~rst;
    assign ack     = fire ? (NREQ'(1) << sel) : '0;
    assign winc    = fire;
    assign wdata   = fire ? data_a[sel] : '0;
    assign gnt_id  = gnt_id_q;
    assign wr_cnt  = wr_cnt_q;

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_q, burst_d, cur;
`endif

    always_comb begin
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        wr_cnt_d = wr_cnt_q;
`ifdef FIFO_ARB_BURST_EN
        burst_d  = burst_q;
        cur      = '0;
`endif
        if (fire) begin
            gnt_id_d = sel;
            wr_cnt_d = wr_cnt_q + CNTW'(1);
`ifdef FIFO_ARB_BURST_EN
            // A new grantee starts a fresh burst; the lock holds ptr on the winner.
            cur = (sel == gnt_id_q) ? burst_q : '0;
            if (int'(cur) + 1 < MAX_BURST) begin
                ptr_d   = sel;
                burst_d = cur + BW'(1);
            end else begin
                ptr_d   = sel_nxt;
                burst_d = '0;
            end
`else
            ptr_d = sel_nxt;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            gnt_id_q <= '0;
            wr_cnt_q <= '0;
`ifdef FIFO_ARB_BURST_EN
            burst_q  <= '0;
`endif
        end else begin
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            wr_cnt_q <= wr_cnt_d;
`ifdef FIFO_ARB_BURST_EN
            burst_q  <= burst_d;
`endif
        end
    end

`ifndef SYNTHESIS
    a_ack_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
    a_winc_ack    : assert property (@(posedge clk) disable iff (rst) winc == |ack);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expectations from a rotating-priority
// reference model, a negedge monitor pops and compares the DUT outputs.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DSIZE     = 6;
    localparam int MAX_BURST = 4;
    localparam int CNTW      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  wfull;
    logic [NREQ-1:0]       ack;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [1:0]            gnt_id;
    logic [CNTW-1:0]       wr_cnt;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .wfull(wfull),
        .ack(ack), .winc(winc), .wdata(wdata), .gnt_id(gnt_id), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ack;
        logic       winc;
        logic [5:0] wdata;
        logic [1:0] gnt;
        logic [3:0] cnt;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   checks = 0;
    int   passes = 0;

    // Reference model: who is first in line, who wrote last, how long the current lock has run.
    int   m_first, m_last, m_total, m_run;
    logic [5:0] d [4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int winner(input logic [3:0] r, input int first);
        for (int k = 0; k < NREQ; k++) begin
            int cand;
            cand = (first + k) % NREQ;
            if (((r >> cand) & 4'd1) != 4'd0) return cand;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic [3:0] rq, input logic wf);
        exp_t e;
        int   w;
        @(posedge clk);
        #1;
        rst      = r;
        req      = rq;
        wfull    = wf;
        req_data = {d[3], d[2], d[1], d[0]};
        if (r) begin
            m_first = 0; m_last = 0; m_total = 0; m_run = 0;
        end
        e.gnt   = 2'(m_last);
        e.cnt   = 4'(m_total % (1 << CNTW));
        e.ack   = '0;
        e.winc  = 1'b0;
        e.wdata = '0;
        w = winner(rq, m_first);
        if (!r && !wf && w >= 0) begin
            e.ack   = 4'(1 << w);
            e.winc  = 1'b1;
            e.wdata = d[2'(w)];
            m_run   = (w == m_last) ? m_run + 1 : 1;
`ifdef FIFO_ARB_BURST_EN
            if (m_run < MAX_BURST) m_first = w;
            else begin m_first = (w + 1) % NREQ; m_run = 0; end
`else
            m_first = (w + 1) % NREQ;
            m_run   = 0;
`endif
            m_last  = w;
            m_total = m_total + 1;
        end
        sbq.push_back(e);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) d[i] = 6'($urandom_range(0, 63));
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            chk("ack",    int'(ack),    int'(me.ack));
            chk("winc",   int'(winc),   int'(me.winc));
            chk("wdata",  int'(wdata),  int'(me.wdata));
            chk("gnt_id", int'(gnt_id), int'(me.gnt));
            chk("wr_cnt", int'(wr_cnt), int'(me.cnt));
        end
    end

    initial begin
        rst = 1'b1; req = '0; wfull = 1'b0; req_data = '0;
        m_first = 0; m_last = 0; m_total = 0; m_run = 0;
        rand_data();

        // Reset with all requesting, then first grant goes to producer 0.
        step(1, 4'b1111, 0);
        step(1, 4'b1111, 0);
        step(0, 4'b1111, 0);

        // Single requester streaming 1..8.
        step(1, 4'b0000, 0);
        for (int i = 1; i <= 8; i++) begin
            d[2] = 6'(i);
            step(0, 4'b0100, 0);
        end
        step(0, 4'b0000, 0);

        // All requesting: rotation.
        step(1, 4'b0000, 0);
        rand_data();
        for (int i = 0; i < 8; i++) step(0, 4'b1111, 0);

        // Stall on wfull after the grant to 1.
        step(1, 4'b0000, 0);
        step(0, 4'b1111, 0);
        step(0, 4'b1111, 0);
        for (int i = 0; i < 3; i++) step(0, 4'b1111, 1);
        step(0, 4'b1111, 0);
        step(0, 4'b0000, 0);

        // Two contenders, then producer 0 dropping out mid-lock.
        step(1, 4'b0000, 0);
        for (int i = 0; i < 9; i++) step(0, 4'b0011, 0);
        step(1, 4'b0000, 0);
        step(0, 4'b0011, 0);
        step(0, 4'b0011, 0);
        step(0, 4'b0010, 0);
        step(0, 4'b0010, 0);

        // Counter wrap: 17 writes.
        step(1, 4'b0000, 0);
        for (int i = 0; i < 17; i++) begin
            rand_data();
            step(0, 4'($urandom_range(1, 15)), 0);
        end
        step(0, 4'b0000, 0);

        // Random traffic with occasional stalls and mid-run resets.
        for (int i = 0; i < 600; i++) begin
            rand_data();
            step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
